// File: rtl/pwl_activation_bwd.sv
// Backward pass of the bipolar PWL activation y = clamp(2x, -1, +1): dL/dx = 2g inside |x| < 0.5, else 0.
// Two-stage valid/ready pipeline with run counters; `PWL_BWD_OVF_FLAG_EN adds a sticky ovf_flag output.
module pwl_activation_bwd #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] g_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [DATA_W-1:0] g_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  cnt_total,
  output logic [CNT_W-1:0]  cnt_gated
`ifdef PWL_BWD_OVF_FLAG_EN
  ,
  output logic              ovf_flag
`endif
);

  // Gate threshold T = 0.5 in the sample format, and the representable range of 2g.
  localparam logic signed [DATA_W-1:0] ThrPos =
      {{(DATA_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ThrNeg = -ThrPos;
  localparam logic signed [DATA_W:0]   DMax   = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0]   DMin   = {2'b11, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]        GMax   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]        GMin   = {1'b1, {(DATA_W-1){1'b0}}};

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_x_q;
  logic [DATA_W-1:0] s1_g_q;
  logic              s1_last_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_g_q;
  logic              s2_last_q;
  logic              s2_gated_q;

  logic [CNT_W-1:0]  cnt_total_q;
  logic [CNT_W-1:0]  cnt_gated_q;

  logic              s1_load;
  logic              s2_load;
  logic              out_fire;
  logic              gate;
  logic signed [DATA_W:0] d;
  logic              sat_hi;
  logic              sat_lo;
  logic [DATA_W-1:0] s2_g_d;

  // No skid buffer: in_ready is combinational from out_ready through both stages.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_fire = s2_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_g_q     <= '0;
      s1_last_q  <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_x_q    <= x_in;
        s1_g_q    <= g_in;
        s1_last_q <= in_last;
      end
    end
  end

  // Strict bounds: |x| = 0.5 already sits in the saturated region of the forward function.
  assign gate = ($signed(s1_x_q) > ThrNeg) && ($signed(s1_x_q) < ThrPos);

  // 2g is exact at DATA_W+1 bits; only the final narrowing can saturate.
  assign d = $signed({s1_g_q, 1'b0});

  always_comb begin
    sat_hi = (d > DMax);
    sat_lo = (d < DMin);
    s2_g_d = d[DATA_W-1:0];
    if (!gate) begin
      s2_g_d = '0;
    end else if (sat_hi) begin
      s2_g_d = GMax;
    end else if (sat_lo) begin
      s2_g_d = GMin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_g_q     <= '0;
      s2_last_q  <= 1'b0;
      s2_gated_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_g_q     <= s2_g_d;
        s2_last_q  <= s1_last_q;
        s2_gated_q <= !gate;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign g_out     = s2_g_q;
  assign out_last  = s2_last_q;

  // Counters survive out_last; software reads them and then pulses stat_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_total_q <= '0;
      cnt_gated_q <= '0;
    end else if (stat_clr) begin
      cnt_total_q <= '0;
      cnt_gated_q <= '0;
    end else if (out_fire) begin
      cnt_total_q <= cnt_total_q + 1'b1;
      if (s2_gated_q) begin
        cnt_gated_q <= cnt_gated_q + 1'b1;
      end
    end
  end

  assign cnt_total = cnt_total_q;
  assign cnt_gated = cnt_gated_q;

`ifdef PWL_BWD_OVF_FLAG_EN
  logic s2_sat_q;
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sat_q <= 1'b0;
    end else if (s2_load && s1_valid_q) begin
      s2_sat_q <= gate && (sat_hi || sat_lo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (stat_clr) begin
      ovf_q <= 1'b0;
    end else if (out_fire && s2_sat_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_flag = ovf_q;
`endif

endmodule

// File: tb/tb_pwl_activation_bwd.sv
// Self-checking bench for pwl_activation_bwd: scoreboard queue filled on accept, drained on transfer.
module tb_pwl_activation_bwd;

  logic        clk;
  logic        rst_n;
  logic [15:0] x_in;
  logic [15:0] g_in;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [15:0] g_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        stat_clr;
  logic [15:0] cnt_total;
  logic [15:0] cnt_gated;
`ifdef PWL_BWD_OVF_FLAG_EN
  logic        ovf_flag;
`endif

  typedef struct packed {
    logic [15:0] g;
    logic        last;
    logic        gated;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_fail;

  pwl_activation_bwd #(
    .DATA_W(16),
    .FRAC_W(12),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_in     (x_in),
    .g_in     (g_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .g_out    (g_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .stat_clr (stat_clr),
    .cnt_total(cnt_total),
    .cnt_gated(cnt_gated)
`ifdef PWL_BWD_OVF_FLAG_EN
    ,
    .ovf_flag (ovf_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of dL/dx for the bipolar PWL activation, in plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] g, input logic last);
    int   xi;
    int   d;
    exp_t e;
    xi      = int'($signed(x));
    d       = 2 * int'($signed(g));
    e.last  = last;
    e.gated = !(xi > -2048 && xi < 2048);
    if (e.gated)         e.g = 16'h0000;
    else if (d > 32767)  e.g = 16'h7fff;
    else if (d < -32768) e.g = 16'h8000;
    else                 e.g = d[15:0];
    return e;
  endfunction

  task automatic pulse_clr();
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (g_out !== 16'h0) begin n_fail++; $display("FAIL reset_g_out: got %h expected 0000", g_out); end
    n_checks++; if (cnt_total !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_total: got %0d expected 0", cnt_total); end
    n_checks++; if (cnt_gated !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_gated: got %0d expected 0", cnt_gated); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
`ifdef PWL_BWD_OVF_FLAG_EN
    n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_flag); end
`endif
  endtask

  task automatic test_latency();
    int edges;
    out_ready = 1'b1;
    @(posedge clk); #1;
    x_in = 16'd1024; g_in = 16'd1000; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    @(negedge clk);
    while (!out_valid && edges < 8) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    n_checks++; if (edges != 2) begin n_fail++; $display("FAIL lat_edges: got %0d expected 2", edges); end
    n_checks++; if (g_out !== 16'd2000) begin n_fail++; $display("FAIL lat_g_out: got %0d expected 2000", g_out); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain: got %b expected 0", out_valid); end
  endtask

  // Linear region, gate edges, zero gradient and saturation, out_ready held high.
  task automatic test_function();
    logic [15:0] tx [11] = '{16'd1024, 16'hfc00, 16'd2048, 16'hf800, 16'd3276, 16'd2047,
                             16'd0, 16'd0, 16'hf801, 16'd5000, 16'd100};
    logic [15:0] tg [11] = '{16'd1000, 16'hfc18, 16'd4096, 16'd4096, 16'd4096, 16'd4096,
                             16'h5000, 16'ha000, 16'd100, 16'd0, 16'd0};
    logic [15:0] te [11] = '{16'd2000, 16'hf830, 16'd0, 16'd0, 16'd0, 16'd8192,
                             16'h7fff, 16'h8000, 16'd200, 16'd0, 16'd0};
    logic        tgt [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   i;
    int   got;
    exp_t e;
    pulse_clr();
    out_ready = 1'b1;
    i = 0; got = 0;
    x_in = tx[0]; g_in = tg[0]; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 100 && got < 11; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL func_spurious: got %h expected none", g_out);
        end else begin
          e = q.pop_front();
          n_checks++;
          if (g_out !== e.g) begin n_fail++; $display("FAIL func_g[%0d]: got %h expected %h", got, g_out, e.g); end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        e.g = te[i]; e.last = 1'b0; e.gated = tgt[i];
        q.push_back(e);
        i++;
      end
      @(posedge clk); #1;
      if (i < 11) begin x_in = tx[i]; g_in = tg[i]; end
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (got != 11) begin n_fail++; $display("FAIL func_timeout: got %0d outputs expected 11", got); end
    n_checks++; if (cnt_total !== 16'd11) begin n_fail++; $display("FAIL func_cnt_total: got %0d expected 11", cnt_total); end
    n_checks++; if (cnt_gated !== 16'd4) begin n_fail++; $display("FAIL func_cnt_gated: got %0d expected 4", cnt_gated); end
`ifdef PWL_BWD_OVF_FLAG_EN
    n_checks++; if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf_flag); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf_flag); end
    pulse_clr();
    @(negedge clk);
    n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf_flag); end
`endif
    q.delete();
  endtask

  // out_ready pattern 1,0,0 repeating; checks order, stability, in_ready and out_last.
  task automatic test_backpressure();
    logic [15:0] sx;
    logic [15:0] sg;
    logic        hold_v;
    logic [15:0] hold_g;
    logic        hold_l;
    int   i;
    int   got;
    exp_t e;
    pulse_clr();
    i = 0; got = 0; hold_v = 1'b0; hold_g = '0; hold_l = 1'b0;
    out_ready = 1'b1;
    sx = 16'(-2500); sg = 16'(-8000);
    x_in = sx; g_in = sg; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 200 && got < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        n_fail++; $display("FAIL bp_in_ready[c%0d]: got %b expected %b", c, in_ready, (q.size() < 2) || out_ready);
      end
      if (hold_v) begin
        n_checks++;
        if (out_valid !== 1'b1 || g_out !== hold_g || out_last !== hold_l) begin
          n_fail++; $display("FAIL bp_stable[c%0d]: got %b/%h/%b expected 1/%h/%b", c, out_valid, g_out, out_last, hold_g, hold_l);
        end
      end
      hold_v = out_valid && !out_ready; hold_g = g_out; hold_l = out_last;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL bp_spurious: got %h expected none", g_out);
        end else begin
          e = q.pop_front();
          n_checks++;
          if (g_out !== e.g || out_last !== e.last) begin
            n_fail++; $display("FAIL bp_out[%0d]: got %h/%b expected %h/%b", got, g_out, out_last, e.g, e.last);
          end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(x_in, g_in, in_last));
        i++;
      end
      @(posedge clk); #1;
      out_ready = ((c + 1) % 3 == 0);
      if (i < 8) begin
        sx = 16'(i * 700 - 2500); sg = 16'(i * 2500 - 8000);
        x_in = sx; g_in = sg; in_last = (i == 7);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL bp_timeout: got %0d outputs expected 8", got); end
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate: got %b expected 0", out_valid); end
      @(posedge clk);
    end
    @(negedge clk);
    n_checks++; if (cnt_total !== 16'd8) begin n_fail++; $display("FAIL bp_cnt_total: got %0d expected 8", cnt_total); end
    n_checks++; if (cnt_gated !== 16'd2) begin n_fail++; $display("FAIL bp_cnt_gated: got %0d expected 2", cnt_gated); end
    q.delete();
  endtask

  // stat_clr in the very cycle of an output transfer wins over the increment.
  task automatic test_clear_same_cycle();
    int waited;
    out_ready = 1'b1;
    @(posedge clk); #1;
    x_in = 16'd0; g_in = 16'd10; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (out_valid !== 1'b1 || g_out !== 16'd20) begin n_fail++; $display("FAIL clr_out: got %b/%0d expected 1/20", out_valid, g_out); end
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt_total !== 16'd0) begin n_fail++; $display("FAIL clr_cnt_total: got %0d expected 0", cnt_total); end
    n_checks++; if (cnt_gated !== 16'd0) begin n_fail++; $display("FAIL clr_cnt_gated: got %0d expected 0", cnt_gated); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_drain: got %b expected 0", out_valid); end
  endtask

  // Two samples stuck in the pipe are dropped by an asynchronous reset.
  task automatic test_reset_midstream();
    out_ready = 1'b1;
    @(posedge clk); #1;
    x_in = 16'd100; g_in = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cnt_total !== 16'd1) begin n_fail++; $display("FAIL rst_pre_cnt: got %0d expected 1", cnt_total); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    x_in = 16'd200; g_in = 16'd9; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_full: got %b/%b expected 0/1", in_ready, out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_emit[c%0d]: got %b expected 0", c, out_valid); end
    end
    n_checks++; if (cnt_total !== 16'd0) begin n_fail++; $display("FAIL rst_cnt_total: got %0d expected 0", cnt_total); end
    n_checks++; if (cnt_gated !== 16'd0) begin n_fail++; $display("FAIL rst_cnt_gated: got %0d expected 0", cnt_gated); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; x_in = '0; g_in = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; stat_clr = 1'b0;
    test_reset();
    test_latency();
    test_function();
    test_backpressure();
    test_clear_same_cycle();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
